sd_cmd_sequencer: RTL

- Upstream master for sdc_controller's byte-wide register bus (addr/data_in/we/data_out).
- On a read request it issues CMD0 (reset) and CMD7 (select card, RCA 0x13) once. It then issues the block-read command with the requested block address.
- After each command it polls the controller status register and reports done or error to the requester.
- Replaces hand-written register pokes with a hardware sequence.

---
 rtl/sd_seq_pkg.sv | 71 +++++++
 rtl/sd_reg_writer.sv | 84 ++++++++
 rtl/sd_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg
// Shared definitions for the SD command sequencer:
//   - sdc_controller register map entries written by the sequencer
//   - sequencer FSM state encoding
//   - command identifiers for the three commands the sequencer issues
//   - helpers that map a frame slot to its register and normalise the block count
// Frame slots: 0 = block count (read command only), 1 = command index,
// 2 = setup, 3..6 = argument bytes from most to least significant.
// Slot 6 writes REG_ARG0, and that write launches the command.
package sd_seq_pkg;

  localparam logic [6:0] REG_ARG0   = 7'h00;
  localparam logic [6:0] REG_ARG1   = 7'h01;
  localparam logic [6:0] REG_ARG2   = 7'h02;
  localparam logic [6:0] REG_ARG3   = 7'h03;
  localparam logic [6:0] REG_SETUP  = 7'h04;
  localparam logic [6:0] REG_CMD    = 7'h05;
  localparam logic [6:0] REG_BLKCNT = 7'h48;

  localparam logic [5:0] CMD0_INDEX = 6'd0;
  localparam logic [5:0] CMD7_INDEX = 6'd7;

  localparam logic [2:0] SLOT_BLKCNT = 3'd0;
  localparam logic [2:0] SLOT_CMD    = 3'd1;
  localparam logic [2:0] SLOT_LAST   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD        = 3'd1,
    ST_WR_SETUP    = 3'd2,
    ST_WR_STROBE   = 3'd3,
    ST_POLL_ADDR   = 3'd4,
    ST_POLL_SAMPLE = 3'd5,
    ST_FINISH      = 3'd6,
    ST_FAIL        = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    CMD_RESET  = 2'd0,
    CMD_SELECT = 2'd1,
    CMD_READ   = 2'd2
  } cmd_id_t;

  // Register address written by a given frame slot.
  function automatic logic [6:0] slot_reg(input logic [2:0] slot);
    logic [6:0] reg_addr;
    case (slot)
      3'd0:    reg_addr = REG_BLKCNT;
      3'd1:    reg_addr = REG_CMD;
      3'd2:    reg_addr = REG_SETUP;
      3'd3:    reg_addr = REG_ARG3;
      3'd4:    reg_addr = REG_ARG2;
      3'd5:    reg_addr = REG_ARG1;
      3'd6:    reg_addr = REG_ARG0;
      default: reg_addr = REG_ARG0;
    endcase
    return reg_addr;
  endfunction

  // A block count of zero is issued as a single block.
  function automatic logic [7:0] blk_count(input logic [7:0] nblk);
    logic [7:0] cnt;
    if (nblk == 8'd0) begin
      cnt = 8'd1;
    end else begin
      cnt = nblk;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sd_reg_writer.sv
// sd_reg_writer
// Owns the controller register bus (addr / data / we) and performs one
// two-cycle register write per start pulse:
//   setup cycle  : addr and data driven, we low
//   strobe cycle : addr and data held, we high
// followed by a one-cycle wr_done. we therefore never stays high for two
// consecutive cycles. While idle, set_addr repoints addr without writing;
// the sequencer uses this to address the status register for polling.
// Ports:
//   clk, rstn_async          clock, asynchronous active-low reset
//   start, wr_addr, wr_data  launch a write (accepted only while idle)
//   set_addr, set_addr_val   load addr with we kept low (idle only)
//   addr, data, we           registered controller bus outputs
//   wr_done                  one-cycle pulse after the strobe cycle
module sd_reg_writer (
  input  logic       clk,
  input  logic       rstn_async,
  input  logic       start,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       set_addr,
  input  logic [6:0] set_addr_val,
  output logic [6:0] addr,
  output logic [7:0] data,
  output logic       we,
  output logic       wr_done
);

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2
  } wr_phase_t;

  wr_phase_t  phase_r;
  logic [6:0] addr_r;
  logic [7:0] data_r;
  logic       we_r;
  logic       wr_done_r;

  // Write handshake: setup cycle, strobe cycle, then done pulse.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      phase_r   <= PH_IDLE;
      addr_r    <= 7'h00;
      data_r    <= 8'h00;
      we_r      <= 1'b0;
      wr_done_r <= 1'b0;
    end else begin
      wr_done_r <= 1'b0;
      case (phase_r)
        PH_IDLE: begin
          we_r <= 1'b0;
          if (start) begin
            addr_r  <= wr_addr;
            data_r  <= wr_data;
            phase_r <= PH_SETUP;
          end else if (set_addr) begin
            addr_r <= set_addr_val;
          end
        end
        PH_SETUP: begin
          we_r    <= 1'b1;
          phase_r <= PH_STROBE;
        end
        PH_STROBE: begin
          we_r      <= 1'b0;
          wr_done_r <= 1'b1;
          phase_r   <= PH_IDLE;
        end
        default: begin
          we_r    <= 1'b0;
          phase_r <= PH_IDLE;
        end
      endcase
    end
  end

  assign addr    = addr_r;
  assign data    = data_r;
  assign we      = we_r;
  assign wr_done = wr_done_r;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer
// Upstream master for the sdc_controller byte-wide register bus. A read
// request issues CMD0 and CMD7 (select, RCA) once if the card is not yet
// initialized, then the block-read command at the requested block address.
// After each command the controller status register is polled until the
// complete or error bit is set, or until TIMEOUT samples have been taken.
// Ports:
//   clk, rstn_async                     clock, asynchronous active-low reset
//   req_valid, req_ready                request handshake (ready only in idle)
//   req_blkaddr, req_nblk               captured when a request is accepted
//   done, error                         one-cycle completion pulses
//   initialized                         CMD0/CMD7 sequence has completed
//   addr, data_out_wr, we, data_in_rd   controller register bus
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter logic [15:0] RCA         = 16'h0013,
  parameter logic [5:0]  READ_CMD    = 6'd18,
  parameter logic [7:0]  SETUP_CMD0  = 8'h00,
  parameter logic [7:0]  SETUP_CMD7  = 8'h00,
  parameter logic [7:0]  SETUP_READ  = 8'h3D,
  parameter logic [6:0]  STATUS_ADDR = 7'h0C,
  parameter logic [15:0] TIMEOUT     = 16'd65535
) (
  input  logic        clk,
  input  logic        rstn_async,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_blkaddr,
  input  logic [7:0]  req_nblk,
  output logic        done,
  output logic        error,
  output logic        initialized,
  output logic [6:0]  addr,
  output logic [7:0]  data_out_wr,
  output logic        we,
  input  logic [7:0]  data_in_rd
);

  // The sample that brings the count to TIMEOUT is the last one allowed.
  localparam logic [15:0] POLL_LAST = TIMEOUT - 16'd1;

  seq_state_t  state_r;
  seq_state_t  state_s;
  cmd_id_t     cmd_r;
  cmd_id_t     cmd_next_s;
  logic [2:0]  slot_r;
  logic [31:0] blkaddr_r;
  logic [7:0]  nblk_r;
  logic [15:0] poll_cnt_r;
  logic        initialized_r;
  logic        req_ready_r;
  logic        done_r;
  logic        error_r;

  logic        capture_s;
  logic        load_s;
  logic        slot_adv_s;
  logic        poll_inc_s;
  logic        cmd_set_s;
  logic        init_set_s;
  logic        init_clr_s;
  logic        wr_start_s;
  logic        poll_addr_s;
  logic        wr_done_s;

  logic [31:0] arg_s;
  logic [5:0]  cmd_index_s;
  logic [7:0]  setup_s;
  logic [6:0]  wr_addr_s;
  logic [7:0]  wr_data_s;

  // Only status bits 0 and 1 carry meaning.
  logic        unused_status_s;
  assign unused_status_s = ^data_in_rd[7:2];

  // FSM state register.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    state_s     = state_r;
    capture_s   = 1'b0;
    load_s      = 1'b0;
    slot_adv_s  = 1'b0;
    poll_inc_s  = 1'b0;
    cmd_set_s   = 1'b0;
    cmd_next_s  = cmd_r;
    init_set_s  = 1'b0;
    init_clr_s  = 1'b0;
    wr_start_s  = 1'b0;
    poll_addr_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          capture_s  = 1'b1;
          cmd_set_s  = 1'b1;
          cmd_next_s = initialized_r ? CMD_READ : CMD_RESET;
          state_s    = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s  = 1'b1;
        state_s = ST_WR_SETUP;
      end
      ST_WR_SETUP: begin
        wr_start_s = 1'b1;
        state_s    = ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        if (!wr_done_s) begin
          state_s = ST_WR_STROBE;
        end else if (slot_r == SLOT_LAST) begin
          state_s = ST_POLL_ADDR;
        end else begin
          slot_adv_s = 1'b1;
          state_s    = ST_WR_SETUP;
        end
      end
      ST_POLL_ADDR: begin
        poll_addr_s = 1'b1;
        state_s     = ST_POLL_SAMPLE;
      end
      ST_POLL_SAMPLE: begin
        // Error bit wins, including when complete is set in the same sample.
        if (data_in_rd[1]) begin
          state_s = ST_FAIL;
        end else if (data_in_rd[0]) begin
          case (cmd_r)
            CMD_RESET: begin
              cmd_set_s  = 1'b1;
              cmd_next_s = CMD_SELECT;
              state_s    = ST_LOAD;
            end
            CMD_SELECT: begin
              cmd_set_s  = 1'b1;
              cmd_next_s = CMD_READ;
              init_set_s = 1'b1;
              state_s    = ST_LOAD;
            end
            CMD_READ: begin
              state_s = ST_FINISH;
            end
            default: begin
              state_s = ST_FAIL;
            end
          endcase
        end else if (poll_cnt_r == POLL_LAST) begin
          state_s = ST_FAIL;
        end else begin
          poll_inc_s = 1'b1;
          state_s    = ST_POLL_ADDR;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      ST_FAIL: begin
        init_clr_s = 1'b1;
        state_s    = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Command-dependent frame contents and the register/byte for the current slot.
  always_comb begin
    arg_s       = 32'h0000_0000;
    cmd_index_s = CMD0_INDEX;
    setup_s     = SETUP_CMD0;
    case (cmd_r)
      CMD_RESET: begin
        arg_s       = 32'h0000_0000;
        cmd_index_s = CMD0_INDEX;
        setup_s     = SETUP_CMD0;
      end
      CMD_SELECT: begin
        arg_s       = {RCA, 16'h0000};
        cmd_index_s = CMD7_INDEX;
        setup_s     = SETUP_CMD7;
      end
      CMD_READ: begin
        arg_s       = blkaddr_r;
        cmd_index_s = READ_CMD;
        setup_s     = SETUP_READ;
      end
      default: begin
        arg_s       = 32'h0000_0000;
        cmd_index_s = CMD0_INDEX;
        setup_s     = SETUP_CMD0;
      end
    endcase

    wr_addr_s = slot_reg(slot_r);
    case (slot_r)
      3'd0:    wr_data_s = nblk_r;
      3'd1:    wr_data_s = {2'b00, cmd_index_s};
      3'd2:    wr_data_s = setup_s;
      3'd3:    wr_data_s = arg_s[31:24];
      3'd4:    wr_data_s = arg_s[23:16];
      3'd5:    wr_data_s = arg_s[15:8];
      3'd6:    wr_data_s = arg_s[7:0];
      default: wr_data_s = 8'h00;
    endcase
  end

  // Request capture, current command, frame slot and poll counter.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      blkaddr_r  <= 32'h0000_0000;
      nblk_r     <= 8'h00;
      cmd_r      <= CMD_RESET;
      slot_r     <= 3'd0;
      poll_cnt_r <= 16'd0;
    end else begin
      if (capture_s) begin
        blkaddr_r <= req_blkaddr;
        nblk_r    <= blk_count(req_nblk);
      end
      if (cmd_set_s) begin
        cmd_r <= cmd_next_s;
      end
      // Only the read frame carries the block-count write.
      if (load_s) begin
        slot_r <= (cmd_r == CMD_READ) ? SLOT_BLKCNT : SLOT_CMD;
      end else if (slot_adv_s) begin
        slot_r <= slot_r + 3'd1;
      end
      if (load_s) begin
        poll_cnt_r <= 16'd0;
      end else if (poll_inc_s) begin
        poll_cnt_r <= poll_cnt_r + 16'd1;
      end
    end
  end

  // Registered requester-facing status outputs.
  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      initialized_r <= 1'b0;
      req_ready_r   <= 1'b0;
      done_r        <= 1'b0;
      error_r       <= 1'b0;
    end else begin
      if (init_clr_s) begin
        initialized_r <= 1'b0;
      end else if (init_set_s) begin
        initialized_r <= 1'b1;
      end
      req_ready_r <= (state_s == ST_IDLE);
      done_r      <= (state_r == ST_FINISH);
      error_r     <= (state_r == ST_FAIL);
    end
  end

  sd_reg_writer u_writer (
    .clk          (clk),
    .rstn_async   (rstn_async),
    .start        (wr_start_s),
    .wr_addr      (wr_addr_s),
    .wr_data      (wr_data_s),
    .set_addr     (poll_addr_s),
    .set_addr_val (STATUS_ADDR),
    .addr         (addr),
    .data         (data_out_wr),
    .we           (we),
    .wr_done      (wr_done_s)
  );

  assign req_ready   = req_ready_r;
  assign done        = done_r;
  assign error       = error_r;
  assign initialized = initialized_r;

endmodule
